// File: rtl/d_ram_msg_checker.sv
// Purpose : reads MSG_LEN bytes from the decrypted-message RAM and checks each is 'a'..'z' or space.
// Latency : (2+READ_LATENCY) cycles per byte; done pulses after (2+READ_LATENCY)*MSG_LEN edges.
// Backpr. : none; start is only sampled in IDLE and ignored while a scan is in progress.
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   start           - begin a scan (sampled only in IDLE)
//   d_ram_q         - D_RAM read data, valid READ_LATENCY edges after d_ram_addr updates
//   d_ram_addr      - registered D_RAM read address
//   busy, done      - scan in progress / one-cycle end-of-scan pulse
//   key_ok          - all checked bytes legal (valid from done until next accepted start)
//   bad_addr        - address of first illegal byte, 0 if none
//   bad_count       - number of illegal bytes found
//
// Optional feature: define MSG_CHECK_EARLY_ABORT_EN to end the scan at the first illegal byte.
module d_ram_msg_checker #(
   parameter int ADDR_W       = 8,
   parameter int MSG_LEN      = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        d_ram_q,
   output logic [ADDR_W-1:0] d_ram_addr,
   output logic              busy,
   output logic              done,
   output logic              key_ok,
   output logic [ADDR_W-1:0] bad_addr,
   output logic [ADDR_W:0]   bad_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET_ADDR,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(MSG_LEN - 1);
   localparam logic [1:0]        WAIT_LAST = 2'(READ_LATENCY - 1);

   state_t            state;
   logic [ADDR_W-1:0] index;
   logic [1:0]        wait_cnt;
   logic              legal;
   logic              end_scan;

   assign legal = ((d_ram_q >= 8'h61) && (d_ram_q <= 8'h7A)) || (d_ram_q == 8'h20);

   // Index is compared before incrementing, so MSG_LEN = 2^ADDR_W stops at all-ones without wrapping.
`ifdef MSG_CHECK_EARLY_ABORT_EN
   assign end_scan = (index == LAST_IDX) || !legal;
`else
   assign end_scan = (index == LAST_IDX);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         index      <= '0;
         wait_cnt   <= '0;
         d_ram_addr <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         key_ok     <= 1'b0;
         bad_addr   <= '0;
         bad_count  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_SET_ADDR;
                  index     <= '0;
                  busy      <= 1'b1;
                  key_ok    <= 1'b1;   // provisional until an illegal byte is seen
                  bad_addr  <= '0;
                  bad_count <= '0;
               end
            end
            S_SET_ADDR: begin
               d_ram_addr <= index;
               wait_cnt   <= '0;
               state      <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  state <= S_CHECK;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            S_CHECK: begin
               if (!legal) begin
                  key_ok    <= 1'b0;
                  bad_count <= bad_count + (ADDR_W+1)'(1);
                  if (bad_count == '0) begin
                     bad_addr <= index;
                  end
               end
               if (end_scan) begin
                  // busy drops as done rises so busy spans exactly the scan length
                  state <= S_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  index <= index + ADDR_W'(1);
                  state <= S_SET_ADDR;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_d_ram_msg_checker.sv
module tb_d_ram_msg_checker;

   localparam int MSG_LEN = 32;
   localparam int NI      = 3;   // instance g has READ_LATENCY = g+1

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] mem [256];

   logic [7:0] addr_o     [NI];
   logic       busy_o     [NI];
   logic       done_o     [NI];
   logic       key_o      [NI];
   logic [7:0] bad_addr_o [NI];
   logic [8:0] bad_cnt_o  [NI];
   logic [7:0] q_i        [NI];

   int vecs = 0;
   int errs = 0;

   // expected values per instance
   int exp_done [NI];
   int exp_end  [NI];
   int exp_kok  [NI];
   int exp_badr [NI];
   int exp_bcnt [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int RL = g + 1;
      logic [7:0] pipe [RL];
      // RAM read model: q appears RL edges after the address register changes
      always @(posedge clk) begin
         pipe[0] <= mem[addr_o[g]];
         for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
      end
      assign q_i[g] = pipe[RL-1];

      d_ram_msg_checker #(.ADDR_W(8), .MSG_LEN(MSG_LEN), .READ_LATENCY(RL)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .start      (start),
         .d_ram_q    (q_i[g]),
         .d_ram_addr (addr_o[g]),
         .busy       (busy_o[g]),
         .done       (done_o[g]),
         .key_ok     (key_o[g]),
         .bad_addr   (bad_addr_o[g]),
         .bad_count  (bad_cnt_o[g])
      );
   end

   function automatic bit is_legal(input logic [7:0] b);
      return (b >= "a" && b <= "z") || b == " ";
   endfunction

   // Reference: results and done edge (counted from the start-sampling edge) from the message contents.
   task automatic build_model();
      for (int g = 0; g < NI; g++) begin
         int first = -1;
         int cnt = 0;
         int last = MSG_LEN - 1;
         for (int i = 0; i < MSG_LEN; i++)
            if (!is_legal(mem[i])) begin
               if (first < 0) first = i;
               cnt++;
            end
`ifdef MSG_CHECK_EARLY_ABORT_EN
         if (first >= 0) begin
            last = first;
            cnt  = 1;
         end
`endif
         exp_kok[g]  = (first < 0) ? 1 : 0;
         exp_badr[g] = (first < 0) ? 0 : first;
         exp_bcnt[g] = cnt;
         exp_end[g]  = last;
         exp_done[g] = (2 + g + 1) * (last + 1);
      end
   endtask

   task automatic fill_legal();
      for (int i = 0; i < 256; i++) mem[i] = 8'h61;
   endtask

   // Runs one scan; restart_at > 0 re-asserts start for the edge with that number.
   task automatic run_scan(input string name, input int restart_at);
      int maxd = 0;
      build_model();
      for (int g = 0; g < NI; g++) if (exp_done[g] > maxd) maxd = exp_done[g];
      @(negedge clk);
      start = 1'b1;
      for (int e = 0; e <= maxd + 2; e++) begin
         @(negedge clk);
         start = (restart_at > 0 && e + 1 == restart_at) ? 1'b1 : 1'b0;
         for (int g = 0; g < NI; g++) begin
            logic eb, ed;
            eb = (e < exp_done[g]);
            ed = (e == exp_done[g]);
            vecs++;
            if (busy_o[g] !== eb) begin
               errs++;
               $display("FAIL %s busy rl=%0d edge=%0d: got %b expected %b", name, g+1, e, busy_o[g], eb);
            end
            vecs++;
            if (done_o[g] !== ed) begin
               errs++;
               $display("FAIL %s done rl=%0d edge=%0d: got %b expected %b", name, g+1, e, done_o[g], ed);
            end
            if (e >= 1) begin
               int ea;
               ea = (e - 1) / (2 + g + 1);
               if (ea > exp_end[g]) ea = exp_end[g];
               vecs++;
               if (addr_o[g] !== 8'(ea)) begin
                  errs++;
                  $display("FAIL %s addr rl=%0d edge=%0d: got %0d expected %0d", name, g+1, e, addr_o[g], ea);
               end
            end
         end
      end
      for (int g = 0; g < NI; g++) begin
         vecs++;
         if (key_o[g] !== 1'(exp_kok[g])) begin
            errs++;
            $display("FAIL %s key_ok rl=%0d: got %b expected %0d", name, g+1, key_o[g], exp_kok[g]);
         end
         vecs++;
         if (bad_addr_o[g] !== 8'(exp_badr[g])) begin
            errs++;
            $display("FAIL %s bad_addr rl=%0d: got %0d expected %0d", name, g+1, bad_addr_o[g], exp_badr[g]);
         end
         vecs++;
         if (bad_cnt_o[g] !== 9'(exp_bcnt[g])) begin
            errs++;
            $display("FAIL %s bad_count rl=%0d: got %0d expected %0d", name, g+1, bad_cnt_o[g], exp_bcnt[g]);
         end
      end
   endtask

   task automatic check_idle_zero(input string name);
      for (int g = 0; g < NI; g++) begin
         vecs++;
         if (addr_o[g] !== 8'd0 || busy_o[g] !== 1'b0 || done_o[g] !== 1'b0 || key_o[g] !== 1'b0 ||
             bad_addr_o[g] !== 8'd0 || bad_cnt_o[g] !== 9'd0) begin
            errs++;
            $display("FAIL %s rl=%0d: got addr=%0d busy=%b done=%b key_ok=%b bad_addr=%0d bad_count=%0d expected all 0",
                     name, g+1, addr_o[g], busy_o[g], done_o[g], key_o[g], bad_addr_o[g], bad_cnt_o[g]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      fill_legal();
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_all_legal();
      string s = "the quick brown fox jumps over t";
      fill_legal();
      for (int i = 0; i < MSG_LEN; i++) mem[i] = s[i];
      run_scan("all_legal", 0);
   endtask

   task automatic test_single_bad();
      fill_legal();
      mem[5] = 8'h41;
      run_scan("single_bad", 0);
   endtask

   task automatic test_boundary();
      fill_legal();
      mem[0] = 8'h60;
      mem[1] = 8'h7B;
      mem[2] = 8'h20;
      mem[3] = 8'h7A;
      run_scan("boundary", 0);
   endtask

   task automatic test_last_byte_bad();
      fill_legal();
      mem[31] = 8'hFF;
      run_scan("last_bad", 0);
   endtask

   task automatic test_start_while_busy();
      fill_legal();
      run_scan("start_busy", 40);
   endtask

   // start held high through DONE: re-accepted on the following IDLE edge, key_ok back to 1
   task automatic test_start_held();
      int maxd = 0;
      fill_legal();
      mem[$urandom_range(0, MSG_LEN-1)] = 8'h00;
      build_model();
      for (int g = 0; g < NI; g++) if (exp_done[g] > maxd) maxd = exp_done[g];
      @(negedge clk);
      start = 1'b1;
      for (int e = 0; e <= maxd + 2; e++) begin
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            if (e == exp_done[g]) begin
               vecs++;
               if (done_o[g] !== 1'b1 || key_o[g] !== 1'b0) begin
                  errs++;
                  $display("FAIL held_done rl=%0d: got done=%b key_ok=%b expected done=1 key_ok=0", g+1, done_o[g], key_o[g]);
               end
            end
            if (e == exp_done[g] + 1) begin
               vecs++;
               if (busy_o[g] !== 1'b0 || done_o[g] !== 1'b0 || key_o[g] !== 1'b0) begin
                  errs++;
                  $display("FAIL held_idle rl=%0d: got busy=%b done=%b key_ok=%b expected 0 0 0", g+1, busy_o[g], done_o[g], key_o[g]);
               end
            end
            if (e == exp_done[g] + 2) begin
               vecs++;
               if (busy_o[g] !== 1'b1 || key_o[g] !== 1'b1 || bad_cnt_o[g] !== 9'd0) begin
                  errs++;
                  $display("FAIL held_restart rl=%0d: got busy=%b key_ok=%b bad_count=%0d expected 1 1 0", g+1, busy_o[g], key_o[g], bad_cnt_o[g]);
               end
            end
         end
      end
      start = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_scan();
      fill_legal();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_zero("reset_mid");
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            vecs++;
            if (done_o[g] !== 1'b0 || busy_o[g] !== 1'b0) begin
               errs++;
               $display("FAIL reset_mid_quiet rl=%0d cyc=%0d: got done=%b busy=%b expected 0 0", g+1, c, done_o[g], busy_o[g]);
            end
         end
      end
      run_scan("after_reset", 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         for (int i = 0; i < 256; i++) mem[i] = 8'h61;
         for (int i = 0; i < MSG_LEN; i++) begin
            if ($urandom_range(0, 7) == 0) begin
               mem[i] = 8'($urandom_range(0, 255));
            end else begin
               int r;
               r = $urandom_range(0, 26);
               mem[i] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
            end
         end
         run_scan("random", 0);
      end
   endtask

   initial begin
      test_reset();
      test_all_legal();
      test_single_bad();
      test_boundary();
      test_last_byte_bad();
      test_start_while_busy();
      test_start_held();
      test_reset_mid_scan();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
